sram_like_bridge: RTL and testbench

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

---
 rtl/sram_like_bridge_if.sv | 38 +++
 rtl/sram_like_bridge.sv | 142 ++++++++++++++
 tb/tb_sram_like_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_bridge_if.sv
// rtl/sram_like_bridge_if.sv - channel-side and SRAM-side signal bundle of the sram-like bridge
interface sram_like_bridge_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic [NCH-1:0]        ch_req;
  logic [NCH-1:0]        ch_wr;
  logic [2*NCH-1:0]      ch_size;
  logic [32*NCH-1:0]     ch_addr;
  logic [DATA_W*NCH-1:0] ch_wdata;
  logic [NCH-1:0]        ch_addr_ok;
  logic [NCH-1:0]        ch_data_ok;
  logic [NCH-1:0]        ch_err;
  logic [DATA_W-1:0]     ch_rdata;

  logic                  sram_en;
  logic [NB-1:0]         sram_wen;
  logic [31:0]           sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;

  logic                  busy;

  // master: the request channels plus the SRAM macro behind the bridge
  modport master (
    output ch_req, ch_wr, ch_size, ch_addr, ch_wdata, sram_rdata,
    input  ch_addr_ok, ch_data_ok, ch_err, ch_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata, busy
  );

  modport slave (
    input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata, sram_rdata,
    output ch_addr_ok, ch_data_ok, ch_err, ch_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata, busy
  );
endinterface

// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - round-robin arbiter of sram-like channels onto one fixed-latency SRAM port
// Optional misalignment trapping is enabled by defining SRAM_BRIDGE_ALIGN_CHK_EN.
module sram_like_bridge #(
  parameter int NCH    = 2,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = RD_LAT
) (
  input  logic              clk,
  input  logic              resetn,
  sram_like_bridge_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [PW-1:0]     id_q [RD_LAT];

  logic              gnt;
  logic [PW-1:0]     gnt_id;
  logic              done;
  logic              mis;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [OB-1:0]     off;
  logic [NB-1:0]     base;
  logic [NB-1:0]     mask;

  // Comparing against the registered count keeps a retiring slot unusable until the next cycle.
  always_comb begin
    int idx;
    gnt    = 1'b0;
    gnt_id = '0;
    idx    = 0;
    if (resetn && (cnt_q < CW'(DEPTH))) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (int'(rr_q) + k) % NCH;
        if (!gnt && bus.ch_req[idx]) begin
          gnt    = 1'b1;
          gnt_id = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt) begin
      rr_d = (int'(gnt_id) == NCH - 1) ? '0 : gnt_id + PW'(1);
    end
  end

  assign sel_wr    = bus.ch_wr[int'(gnt_id)];
  assign sel_size  = bus.ch_size[2*int'(gnt_id) +: 2];
  assign sel_addr  = bus.ch_addr[32*int'(gnt_id) +: 32];
  assign sel_wdata = bus.ch_wdata[DATA_W*int'(gnt_id) +: DATA_W];
  assign off       = sel_addr[OB-1:0];

  // A doubleword write has no lanes to land in on a 32-bit SRAM, so it writes nothing.
  always_comb begin
    base = '0;
    case (sel_size)
      2'd0:    base = NB'(1);
      2'd1:    base = NB'(3);
      2'd2:    base = NB'(15);
      default: base = (NB == 8) ? '1 : '0;
    endcase
    mask = base << off;
  end

`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
  always_comb begin
    mis = 1'b0;
    case (sel_size)
      2'd1:    mis = sel_addr[0];
      2'd2:    mis = |sel_addr[1:0];
      2'd3:    mis = |sel_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign done = vld_q[RD_LAT-1];

  always_comb begin
    cnt_d = cnt_q + CW'(gnt) - CW'(done);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        id_q[s] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      vld_q[0] <= gnt;
      err_q[0] <= gnt && mis;
      id_q[0]  <= gnt_id;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  always_comb begin
    bus.ch_addr_ok = '0;
    bus.ch_data_ok = '0;
    bus.ch_err     = '0;
    if (gnt) begin
      bus.ch_addr_ok[gnt_id] = 1'b1;
    end
    if (done) begin
      bus.ch_data_ok[id_q[RD_LAT-1]] = 1'b1;
      bus.ch_err[id_q[RD_LAT-1]]     = err_q[RD_LAT-1];
    end
  end

  // A trapped access is acknowledged and retired, but never reaches the SRAM.
  assign bus.sram_en    = gnt && !mis;
  assign bus.sram_wen   = (gnt && sel_wr && !mis) ? mask : '0;
  assign bus.sram_addr  = {sel_addr[31:OB], {OB{1'b0}}};
  assign bus.sram_wdata = sel_wdata;
  assign bus.ch_rdata   = bus.sram_rdata;
  assign bus.busy       = (cnt_q != '0);

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - randomized and directed checks of sram_like_bridge against a transaction model
module tb_sram_like_bridge;
  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int DEP = 2;
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sram_like_bridge_if #(.NCH(NCH), .DATA_W(DW)) bif ();
  sram_like_bridge_if #(.NCH(NCH), .DATA_W(DW)) aif ();

  sram_like_bridge #(.NCH(NCH), .DATA_W(DW), .RD_LAT(LAT), .DEPTH(DEP)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bif.slave));
  sram_like_bridge #(.NCH(NCH), .DATA_W(DW), .RD_LAT(1), .DEPTH(1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(aif.slave));

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // SRAM behind dut_b: byte-lane writes, reads returned LAT cycles after the access
  logic [31:0] bmem [16];
  logic [31:0] bpipe [LAT];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
    end else if (bif.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bif.sram_wen[b]) bmem[bif.sram_addr[5:2]][8*b +: 8] <= bif.sram_wdata[8*b +: 8];
    end
    bpipe[0] <= bmem[bif.sram_addr[5:2]];
    for (int s = 1; s < LAT; s++) bpipe[s] <= bpipe[s-1];
  end
  assign bif.sram_rdata = bpipe[LAT-1];

  // Reference model state
  typedef struct { int id; int due; bit rd; bit err; logic [31:0] data; } resp_t;
  resp_t       exp_q[$];
  logic [31:0] rmem [16];
  int          rr;
  bit          pend [NCH];
  bit          pwr  [NCH];
  logic [1:0]  psz  [NCH];
  logic [31:0] paddr[NCH];
  logic [31:0] pwd  [NCH];

  // Lanes covered by the access: bytes off .. off+size-1 of the word
  function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [31:0] a);
    int n;
    int o;
    logic [3:0] m;
    n = 1 << sz;
    o = int'(a[1:0]);
    m = 4'b0;
    if (sz != 2'd3)
      for (int b = 0; b < 4; b++) if (b >= o && b < o + n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic bit trap(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN && ((a % (32'd1 << sz)) != 0);
  endfunction

  task automatic drive_b();
    for (int c = 0; c < NCH; c++) begin
      bif.ch_req[c]            = pend[c];
      bif.ch_wr[c]             = pwr[c];
      bif.ch_size[2*c +: 2]    = psz[c];
      bif.ch_addr[32*c +: 32]  = paddr[c];
      bif.ch_wdata[32*c +: 32] = pwd[c];
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rr = 0;
    for (int c = 0; c < NCH; c++) begin
      pend[c] = 1'b0; pwr[c] = 1'b0; psz[c] = 2'd0; paddr[c] = 32'h1000; pwd[c] = 32'h0;
    end
    for (int i = 0; i < 16; i++) rmem[i] = init_word(i);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    model_reset();
    drive_b();
    aif.ch_req = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    bif.ch_req = 2'b11;
    aif.ch_req = 2'b11;
    @(negedge clk);
    total++; if (bif.ch_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_aok_b got=%b exp=00", bif.ch_addr_ok); end
    total++; if (bif.sram_en !== 1'b0) begin bad++; $display("FAIL rst_en_b got=%b exp=0", bif.sram_en); end
    total++; if (bif.sram_wen !== 4'b0) begin bad++; $display("FAIL rst_wen_b got=%b exp=0000", bif.sram_wen); end
    total++; if (bif.ch_data_ok !== 2'b00) begin bad++; $display("FAIL rst_dok_b got=%b exp=00", bif.ch_data_ok); end
    total++; if (bif.ch_err !== 2'b00) begin bad++; $display("FAIL rst_err_b got=%b exp=00", bif.ch_err); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_b got=%b exp=0", bif.busy); end
    total++; if (aif.ch_addr_ok !== 2'b00) begin bad++; $display("FAIL rst_aok_a got=%b exp=00", aif.ch_addr_ok); end
    total++; if (aif.sram_en !== 1'b0) begin bad++; $display("FAIL rst_en_a got=%b exp=0", aif.sram_en); end
    @(posedge clk); #1;
    resetn = 1'b1;
    bif.ch_req = 2'b00;
    aif.ch_req = 2'b00;
    @(negedge clk);
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL rel_busy_b got=%b exp=0", bif.busy); end
  endtask

  task automatic test_lat1();
    logic [1:0] aok_t [4];
    logic [1:0] dok_t [4];
    aif.sram_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    aif.ch_req = 2'b01; aif.ch_wr = 2'b00; aif.ch_size = 4'b1010; aif.ch_addr = {32'h0000_1004, 32'h0000_1000};
    @(negedge clk);
    total++; if (aif.ch_addr_ok !== 2'b01) begin bad++; $display("FAIL lat1_aok got=%b exp=01", aif.ch_addr_ok); end
    total++; if (aif.sram_en !== 1'b1 || aif.sram_addr !== 32'h1000) begin bad++; $display("FAIL lat1_sram got=%b/%h exp=1/00001000", aif.sram_en, aif.sram_addr); end
    @(posedge clk); #1;
    aif.ch_req = 2'b00;
    @(negedge clk);
    total++; if (aif.ch_data_ok !== 2'b01) begin bad++; $display("FAIL lat1_dok got=%b exp=01", aif.ch_data_ok); end
    total++; if (aif.ch_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lat1_rdata got=%h exp=deadbeef", aif.ch_rdata); end
    // one slot: a retiring response frees it only for the following cycle
    do_reset();
    aok_t = '{2'b01, 2'b00, 2'b10, 2'b00};
    dok_t = '{2'b00, 2'b01, 2'b00, 2'b10};
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      aif.ch_req = (c < 3) ? 2'b11 : 2'b00;
      @(negedge clk);
      total++; if (aif.ch_addr_ok !== aok_t[c]) begin bad++; $display("FAIL lat1_b2b_aok c=%0d got=%b exp=%b", c, aif.ch_addr_ok, aok_t[c]); end
      total++; if (aif.ch_data_ok !== dok_t[c]) begin bad++; $display("FAIL lat1_b2b_dok c=%0d got=%b exp=%b", c, aif.ch_data_ok, dok_t[c]); end
    end
    @(posedge clk); #1 aif.ch_req = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] aok_t [10];
    logic [1:0] dok_t [10];
    logic       bsy_t [10];
    do_reset();
    aok_t = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    dok_t = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    bsy_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      bif.ch_req = (c < 6) ? 2'b11 : 2'b00;
      bif.ch_wr = 2'b00; bif.ch_size = 4'b1010; bif.ch_addr = {32'h0000_1004, 32'h0000_1000};
      @(negedge clk);
      total++; if (bif.ch_addr_ok !== aok_t[c]) begin bad++; $display("FAIL b2b_aok c=%0d got=%b exp=%b", c, bif.ch_addr_ok, aok_t[c]); end
      total++; if (bif.ch_data_ok !== dok_t[c]) begin bad++; $display("FAIL b2b_dok c=%0d got=%b exp=%b", c, bif.ch_data_ok, dok_t[c]); end
      total++; if (bif.busy !== bsy_t[c]) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, bif.busy, bsy_t[c]); end
      total++; if (bif.sram_en !== (aok_t[c] != 2'b00)) begin bad++; $display("FAIL b2b_en c=%0d got=%b exp=%b", c, bif.sram_en, aok_t[c] != 2'b00); end
    end
  endtask

  task automatic test_lanes();
    int          ch_t  [4];
    bit          wr_t  [4];
    logic [1:0]  sz_t  [4];
    logic [31:0] ad_t  [4];
    logic [31:0] sa_t  [4];
    logic [3:0]  wen_t [4];
    logic [31:0] wd    [4];
    logic [31:0] w0;
    logic [31:0] erd;
    do_reset();
    ch_t = '{1, 1, 0, 0};
    wr_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    sz_t = '{2'd0, 2'd1, 2'd2, 2'd2};
    ad_t = '{32'h2003, 32'h2002, 32'h2004, 32'h2000};
    sa_t = '{32'h2000, 32'h2000, 32'h2004, 32'h2000};
    wen_t = '{4'b1000, 4'b1100, 4'b1111, 4'b0000};
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    w0 = init_word(0);
    erd = {wd[1][31:16], w0[15:0]};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bif.ch_req = 2'b01 << ch_t[i];
      bif.ch_wr  = wr_t[i] ? (2'b01 << ch_t[i]) : 2'b00;
      bif.ch_size[2*ch_t[i] +: 2]   = sz_t[i];
      bif.ch_addr[32*ch_t[i] +: 32] = ad_t[i];
      bif.ch_wdata[32*ch_t[i] +: 32] = wd[i];
      @(negedge clk);
      total++; if (bif.ch_addr_ok !== (2'b01 << ch_t[i])) begin bad++; $display("FAIL lane_aok op=%0d got=%b", i, bif.ch_addr_ok); end
      total++; if (bif.sram_wen !== wen_t[i]) begin bad++; $display("FAIL lane_wen op=%0d got=%b exp=%b", i, bif.sram_wen, wen_t[i]); end
      total++; if (bif.sram_addr !== sa_t[i]) begin bad++; $display("FAIL lane_addr op=%0d got=%h exp=%h", i, bif.sram_addr, sa_t[i]); end
      total++; if (bif.sram_en !== 1'b1 || bif.sram_wdata !== wd[i]) begin bad++; $display("FAIL lane_wdata op=%0d got=%b/%h exp=1/%h", i, bif.sram_en, bif.sram_wdata, wd[i]); end
      @(posedge clk); #1;
      bif.ch_req = 2'b00;
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      total++; if (bif.ch_data_ok !== (2'b01 << ch_t[i])) begin bad++; $display("FAIL lane_dok op=%0d got=%b", i, bif.ch_data_ok); end
      if (!wr_t[i]) begin
        total++; if (bif.ch_rdata !== erd) begin bad++; $display("FAIL lane_rdata got=%h exp=%h", bif.ch_rdata, erd); end
      end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0] ewen;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ewen = (i == 1 && !ALIGN) ? 4'b1110 : 4'b0000;
      @(posedge clk); #1;
      bif.ch_req = 2'b01; bif.ch_wr = (i == 1) ? 2'b01 : 2'b00; bif.ch_size = 4'b0010;
      bif.ch_addr = {32'h0000_1000, (i == 1) ? 32'h0000_1001 : 32'h0000_1002};
      @(negedge clk);
      total++; if (bif.ch_addr_ok !== 2'b01) begin bad++; $display("FAIL mis_aok i=%0d got=%b exp=01", i, bif.ch_addr_ok); end
      total++; if (bif.sram_en !== !ALIGN) begin bad++; $display("FAIL mis_en i=%0d got=%b exp=%b", i, bif.sram_en, !ALIGN); end
      total++; if (bif.sram_wen !== ewen) begin bad++; $display("FAIL mis_wen i=%0d got=%b exp=%b", i, bif.sram_wen, ewen); end
      @(posedge clk); #1;
      bif.ch_req = 2'b00;
      @(negedge clk);
      total++; if (bif.ch_err !== 2'b00) begin bad++; $display("FAIL mis_err_early i=%0d got=%b exp=00", i, bif.ch_err); end
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      total++; if (bif.ch_data_ok !== 2'b01) begin bad++; $display("FAIL mis_dok i=%0d got=%b exp=01", i, bif.ch_data_ok); end
      total++; if (bif.ch_err !== {1'b0, ALIGN}) begin bad++; $display("FAIL mis_err i=%0d got=%b exp=%b", i, bif.ch_err, {1'b0, ALIGN}); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(posedge clk); #1;
    bif.ch_req = 2'b01; bif.ch_wr = 2'b00; bif.ch_size = 4'b1010; bif.ch_addr = {32'h0000_1004, 32'h0000_1000};
    @(negedge clk);
    total++; if (bif.ch_addr_ok !== 2'b01) begin bad++; $display("FAIL mid_aok got=%b exp=01", bif.ch_addr_ok); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      resetn = 1'b0;
      bif.ch_req = 2'b11;
      @(negedge clk);
      total++; if (bif.ch_addr_ok !== 2'b00 || bif.ch_data_ok !== 2'b00) begin bad++; $display("FAIL mid_in_rst c=%0d got=%b/%b exp=00/00", c, bif.ch_addr_ok, bif.ch_data_ok); end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    bif.ch_req = 2'b00;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      total++; if (bif.ch_data_ok !== 2'b00 || bif.busy !== 1'b0) begin bad++; $display("FAIL mid_after c=%0d got=%b/%b exp=00/0", c, bif.ch_data_ok, bif.busy); end
      @(posedge clk); #1;
    end
    bif.ch_req = 2'b11;
    @(negedge clk);
    total++; if (bif.ch_addr_ok !== 2'b01) begin bad++; $display("FAIL mid_first got=%b exp=01", bif.ch_addr_ok); end
    @(posedge clk); #1 bif.ch_req = 2'b00;
  endtask

  task automatic test_random(input int n);
    int gnt;
    bit due;
    bit mis;
    logic [NCH-1:0] e_aok, e_dok, e_err;
    logic [3:0] e_wen;
    logic [31:0] a;
    resp_t r;
    do_reset();
    for (int cyc = 0; cyc < n; cyc++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && cyc < n - 2*LAT - 6 && $urandom_range(0, 99) < 55) begin
          pend[c]  = 1'b1;
          pwr[c]   = 1'($urandom_range(0, 1));
          psz[c]   = 2'($urandom_range(0, 3));
          paddr[c] = 32'h1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
          pwd[c]   = $urandom;
        end
      end
      drive_b();
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      gnt = -1;
      if (exp_q.size() < DEP)
        for (int k = 0; k < NCH; k++) if (gnt < 0 && pend[(rr + k) % NCH]) gnt = (rr + k) % NCH;
      e_aok = (gnt >= 0) ? (NCH'(1) << gnt) : '0;
      e_dok = due ? (NCH'(1) << exp_q[0].id) : '0;
      e_err = (due && exp_q[0].err) ? e_dok : '0;
      mis   = (gnt >= 0) && trap(psz[gnt], paddr[gnt]);
      e_wen = (gnt >= 0 && pwr[gnt] && !mis) ? exp_mask(psz[gnt], paddr[gnt]) : 4'b0;
      @(negedge clk);
      total++; if (bif.ch_addr_ok !== e_aok) begin bad++; $display("FAIL rnd_aok cyc=%0d got=%b exp=%b", cyc, bif.ch_addr_ok, e_aok); end
      total++; if (bif.sram_en !== (gnt >= 0 && !mis)) begin bad++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, bif.sram_en, gnt >= 0 && !mis); end
      total++; if (bif.sram_wen !== e_wen) begin bad++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", cyc, bif.sram_wen, e_wen); end
      total++; if (bif.ch_data_ok !== e_dok) begin bad++; $display("FAIL rnd_dok cyc=%0d got=%b exp=%b", cyc, bif.ch_data_ok, e_dok); end
      total++; if (bif.ch_err !== e_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bif.ch_err, e_err); end
      total++; if (bif.busy !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bif.busy, exp_q.size() != 0); end
      if (gnt >= 0 && !mis) begin
        total++; if (bif.sram_addr !== (paddr[gnt] & ~32'd3)) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bif.sram_addr, paddr[gnt] & ~32'd3); end
        total++; if (bif.sram_wdata !== pwd[gnt]) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bif.sram_wdata, pwd[gnt]); end
      end
      if (due && exp_q[0].rd && !exp_q[0].err) begin
        total++; if (bif.ch_rdata !== exp_q[0].data) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bif.ch_rdata, exp_q[0].data); end
      end
      if (due) void'(exp_q.pop_front());
      if (gnt >= 0) begin
        a = paddr[gnt];
        r.id = gnt; r.due = cyc + LAT; r.rd = !pwr[gnt]; r.err = mis; r.data = rmem[a[5:2]];
        exp_q.push_back(r);
        for (int b = 0; b < 4; b++) if (e_wen[b]) rmem[a[5:2]][8*b +: 8] = pwd[gnt][8*b +: 8];
        rr = (gnt + 1) % NCH;
        pend[gnt] = 1'b0;
      end
    end
    total++; if (exp_q.size() != 0 || bif.busy !== 1'b0) begin bad++; $display("FAIL rnd_drain left=%0d busy=%b exp=0/0", exp_q.size(), bif.busy); end
  endtask

  initial begin
    bif.ch_req = '0; bif.ch_wr = '0; bif.ch_size = '0; bif.ch_addr = '0; bif.ch_wdata = '0;
    aif.ch_req = '0; aif.ch_wr = '0; aif.ch_size = '0; aif.ch_addr = '0; aif.ch_wdata = '0;
    aif.sram_rdata = '0;
    model_reset();
    test_reset();
    test_lat1();
    test_back_to_back();
    test_lanes();
    test_misaligned();
    test_reset_midflight();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
